// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch path: the NOP encoding,
// prefetch depth and the {pc, instr} record carried through the prefetch buffer.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order prefetch buffer. Head is entry 0.
// A pop against an empty buffer is ignored, so a same-edge push is never bypassed.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         clr,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t data_in,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [0:FIFO_DEPTH-1];
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign head   = mem[0];

    always_ff @(posedge clk) begin
        if (clr || flush) begin
            count <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    mem[count[0]] <= data_in;
                    count         <= count + 2'd1;
                end
                2'b01: begin
                    mem[0] <= mem[1];
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        mem[0] <= data_in;
                    end else begin
                        mem[0] <= mem[1];
                        mem[1] <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (clr)
        !(push && !do_pop && count == 2'(FIFO_DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests to imem, in-order response
// tracking with redirect discards, prefetch buffer and the IF/ID registers.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] PC_out,
    output logic        valid_out,
    output logic        bubble
);

    logic [31:0]  fetch_pc;
    logic [1:0]   inflight;
    logic [1:0]   discard;
    logic [31:0]  pend_q [0:1];
    logic [1:0]   pend_cnt;
    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t fifo_in;

    logic accept;
    logic rsp;
    logic keep;
    logic pop;

    // Credit covers both outstanding requests and buffered entries, so the
    // buffer can always absorb every response that comes back.
    assign imem_req  = !clr && !redirect
                     && (3'({1'b0, inflight}) + 3'({1'b0, fifo_count}) < 3'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign rsp       = imem_rvalid && (inflight != 2'd0);
    assign keep      = rsp && (discard == 2'd0);
    assign pop       = !clr && !redirect && !stall;
    assign fifo_in   = '{pc: pend_q[0], instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (clr) begin
            fetch_pc <= RESET_PC;
            inflight <= 2'd0;
            discard  <= 2'd0;
        end else begin
            if (redirect)    fetch_pc <= redirect_pc;
            else if (accept) fetch_pc <= fetch_pc + 32'd4;

            case ({accept, rsp})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: ;
            endcase

            if (redirect)
                discard <= inflight - {1'b0, rsp};
            else if (rsp && discard != 2'd0)
                discard <= discard - 2'd1;
        end
    end

    // PCs of live (non-discarded) requests, oldest first.
    always_ff @(posedge clk) begin
        if (clr || redirect) begin
            pend_cnt <= 2'd0;
        end else begin
            case ({accept, keep})
                2'b10: begin
                    pend_q[pend_cnt[0]] <= fetch_pc;
                    pend_cnt            <= pend_cnt + 2'd1;
                end
                2'b01: begin
                    pend_q[0] <= pend_q[1];
                    pend_cnt  <= pend_cnt - 2'd1;
                end
                2'b11: begin
                    if (pend_cnt == 2'd1) begin
                        pend_q[0] <= fetch_pc;
                    end else begin
                        pend_q[0] <= pend_q[1];
                        pend_q[1] <= fetch_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .clr     (clr),
        .flush   (redirect),
        .push    (keep && !redirect),
        .data_in (fifo_in),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (clr || redirect) begin
            instr_out <= NOP_INSTR;
            PC_out    <= 32'd0;
            valid_out <= 1'b0;
            bubble    <= 1'b0;
        end else if (stall) begin
            bubble <= 1'b1;
        end else begin
            bubble <= 1'b0;
            if (fifo_count != 2'd0) begin
                instr_out <= fifo_head.instr;
                PC_out    <= fifo_head.pc;
                valid_out <= 1'b1;
            end else begin
                instr_out <= NOP_INSTR;
                PC_out    <= 32'd0;
                valid_out <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (clr)
        !(imem_rvalid && inflight == 2'd0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order instruction memory model
// that answers accepted requests after a programmable delay.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        clr, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out, PC_out;
    logic        valid_out, bubble;

    fetch_unit dut (
        .clk         (clk),
        .clr         (clr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .PC_out      (PC_out),
        .valid_out   (valid_out),
        .bubble      (bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       pend [$];
    logic [31:0] got [$];
    int          n_vec = 0, n_err = 0;
    int          cyc = 0, delay = 1;
    int          total_acc = 0, delivered = 0, outstanding = 0;
    logic [31:0] exp_pc = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory answers, edge, then the delivered-stream monitor.
    task automatic cycle();
        logic        acc, rsp, st, rd, cl;
        logic [31:0] acc_addr, rpc;
        rsp = 1'b0;
        if (!clr && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            rsp         = 1'b1;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        acc      = imem_req && imem_ready;
        acc_addr = imem_addr;
        st = stall; rd = redirect; cl = clr; rpc = redirect_pc;
        @(posedge clk);
        #1;
        if (rsp) void'(pend.pop_front());
        if (acc) begin
            pend.push_back('{addr: acc_addr, due: cyc + delay});
            total_acc++;
        end
        cyc++;
        if (cl) begin
            pend.delete();
            exp_pc      = 32'd0;
            outstanding = 0;
        end else if (rd) begin
            exp_pc      = rpc;
            outstanding = 0;
        end else begin
            if (acc) outstanding++;
            if (!st && valid_out) begin
                outstanding--;
                check("stream_pc", PC_out, exp_pc);
                check("stream_instr", instr_out, mem_word(exp_pc));
                got.push_back(PC_out);
                exp_pc += 32'd4;
                delivered++;
            end
            check("credit_bound", 32'(outstanding <= 2), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0;
        clr = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;

        // reset state
        cycle(); cycle();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_instr", instr_out, 32'h0000_0013);
        check("rst_pc", PC_out, 32'd0);
        check("rst_bubble", 32'(bubble), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);

        // free run: first instruction at the 3rd edge
        clr = 1'b0;
        cycle(); check("fr_e1_valid", 32'(valid_out), 32'd0);
        cycle(); check("fr_e2_valid", 32'(valid_out), 32'd0);
        cycle(); check("fr_e3_valid", 32'(valid_out), 32'd1);
        check("fr_e3_pc", PC_out, 32'd0);
        cycle(); check("fr_e4_pc", PC_out, 32'd4);
        for (int i = 0; i < 10 && !(valid_out && PC_out == 32'd8); i++) cycle();
        check("fr_reach_8", PC_out, 32'd8);

        // stall three cycles holding PC 8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_pc", PC_out, 32'd8);
            check("stall_valid", 32'(valid_out), 32'd1);
            check("stall_bubble", 32'(bubble), 32'd1);
        end
        check("stall_no_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        cycle();
        check("resume_pc", PC_out, 32'h0000_000C);
        check("resume_bubble", 32'(bubble), 32'd0);
        for (int i = 0; i < 6; i++) cycle();

        // redirect with two requests in flight
        clr = 1'b1; delay = 3; cycle(); clr = 1'b0;
        a0 = total_acc;
        cycle(); cycle();
        check("redir_two_inflight", 32'(total_acc - a0), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        check("redir_valid", 32'(valid_out), 32'd0);
        check("redir_instr", instr_out, 32'h0000_0013);
        for (int i = 0; i < 20 && !valid_out; i++) cycle();
        check("redir_first_valid", 32'(valid_out), 32'd1);
        check("redir_first_pc", PC_out, 32'h0000_0100);

        // redirect beats stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        stall = 1'b0; redirect = 1'b0;
        check("rs_valid", 32'(valid_out), 32'd0);
        check("rs_instr", instr_out, 32'h0000_0013);
        check("rs_pc", PC_out, 32'd0);
        check("rs_bubble", 32'(bubble), 32'd0);
        for (int i = 0; i < 20 && !valid_out; i++) cycle();
        check("rs_next_pc", PC_out, 32'h0000_0200);

        // toggling ready with random response delays
        clr = 1'b1; cycle(); clr = 1'b0;
        d0 = delivered;
        for (int i = 0; i < 60; i++) begin
            imem_ready = (i % 2 == 0);
            delay = $urandom_range(1, 3);
            cycle();
        end
        imem_ready = 1'b1;
        check("toggle_progress", 32'(delivered - d0 >= 5), 32'd1);

        // address wrap
        clr = 1'b1; delay = 1; cycle(); clr = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        got.delete();
        for (int i = 0; i < 20 && got.size() < 3; i++) cycle();
        check("wrap_count", 32'(got.size()), 32'd3);
        check("wrap_pc0", (got.size() > 0) ? got[0] : 32'hBAD0_BAD0, 32'hFFFF_FFF8);
        check("wrap_pc1", (got.size() > 1) ? got[1] : 32'hBAD0_BAD0, 32'hFFFF_FFFC);
        check("wrap_pc2", (got.size() > 2) ? got[2] : 32'hBAD0_BAD0, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: NOP_INSTR, 32'h0000_0013, instruction driven on instr_out when no valid instruction is present.
REQ-003 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have ports: clr  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: stall  in  1  hazard hold; IF/ID output registers keep their value.
REQ-006 SHALL have ports: redirect  in  1  taken branch/jump; flush and refetch.
REQ-007 SHALL have ports: redirect_pc  in  32  new fetch address.
REQ-008 SHALL have ports: imem_req  out  1  fetch request valid.
REQ-009 SHALL have ports: imem_addr  out  32  fetch address, word aligned.
REQ-010 SHALL have ports: imem_ready  in  1  request accepted when imem_req and imem_ready are both high.
REQ-011 SHALL have ports: imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
REQ-012 SHALL have ports: imem_rdata  in  32  response instruction.
REQ-013 SHALL have ports: instr_out  out  32  IF/ID instruction to decode.
REQ-014 SHALL have ports: PC_out  out  32  IF/ID PC of instr_out.
REQ-015 SHALL have ports: valid_out  out  1  instr_out is a real instruction.
REQ-016 SHALL have ports: bubble  out  1  high for the cycle after a stall-held edge.

Function
REQ-017 SHALL keep fetch_pc, a 2-bit inflight count (accepted, not yet returned), a 2-bit discard count and a 2-entry in-order prefetch FIFO holding {pc, instr}.
REQ-018 SHALL drive imem_req = !redirect && (inflight + fifo_count < 2); imem_addr = fetch_pc.
REQ-019 SHALL on acceptance, in the same edge, capture fetch_pc into the FIFO pending-PC queue, set fetch_pc <= fetch_pc + 4 (32-bit wrap from FFFF_FFFC to 0) and increment inflight.
REQ-020 SHALL on imem_rvalid decrement inflight; if discard != 0, decrement discard and drop the data; otherwise push {oldest pending PC, imem_rdata} into the FIFO.
REQ-021 SHALL, when stall=0 and redirect=0 at an edge, load the IF/ID registers from the FIFO head and pop it (valid_out=1); if the FIFO is empty, load NOP_INSTR, PC_out=0, valid_out=0.
REQ-022 SHALL, when stall=1 and redirect=0, hold instr_out/PC_out/valid_out, not pop, and set bubble=1; otherwise bubble=0.
REQ-023 SHALL on redirect (priority over stall):
  - fetch_pc <= redirect_pc;
  - FIFO emptied;
  - discard <= inflight minus any response arriving that cycle;
  - IF/ID loaded with NOP_INSTR, PC 0, valid 0.
REQ-024 SHALL accept a push and a pop on the same edge; a pop from an empty FIFO that coincides with a push SHALL NOT bypass (the output gets the bubble, the FIFO keeps the entry).
REQ-025 SHALL never overflow the FIFO; the credit rule in REQ-018 guarantees this, and an assertion SHALL check it.
REQ-026 SHALL ignore imem_rvalid when inflight == 0 (assertion flags it).
REQ-027 SHALL take latency from an accepted request (response next cycle, no stall) to valid_out as 2 edges.

Reset
REQ-028 SHALL when clr=1 at an edge (priority over redirect and stall) set:
  - fetch_pc=RESET_PC;
  - inflight=0, discard=0, FIFO empty;
  - instr_out=NOP_INSTR, PC_out=0, valid_out=0, bubble=0.
REQ-029 SHALL drive imem_req=0 during the clr cycle; responses to requests issued before a mid-operation clr are the memory's responsibility to cancel.

Structure
REQ-030 SHALL place NOP_INSTR, the FIFO depth (2) and the {pc,instr} fetch-entry record type in the shared core package.
REQ-031 SHALL implement the prefetch buffer as one sub-module, fetch_fifo (2 entries, push/pop/flush, count output).

Verification
REQ-032 SHALL cover reset then free run: imem_ready=1, response 1 cycle later -> PC_out 0,4,8,... each cycle from the 3rd edge, valid_out=1.
REQ-033 SHALL cover stall for 3 cycles with PC_out=8 -> PC_out holds 8, bubble=1 for those cycles, no fetch beyond 2 buffered plus inflight, then resume with PC_out=C.
REQ-034 SHALL cover redirect to 0x100 with 2 requests inflight -> both responses dropped, next valid_out=1 has PC_out=0x100, valid_out=0 in between.
REQ-035 SHALL cover redirect and stall asserted together -> redirect wins: valid_out=0, instr_out=0x00000013 next cycle.
REQ-036 SHALL cover imem_ready toggling 1,0,1,0 with random response delays -> the PC sequence is contiguous with no duplicates or holes, and the FIFO never exceeds 2.
REQ-037 SHALL cover fetch_pc starting at 0xFFFF_FFF8 -> PC_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
